// File: rtl/dot_product_stage_pkg.sv
// Shared arithmetic definitions for the dot-product stage: Q16.16 p_float types,
// core latencies, and the DP_MULT / DP_ADD core macros used by the datapath.
package dot_product_stage_pkg;

    localparam int FLOAT_W  = 32;
    localparam int FRAC_W   = 16;

    // Signed fixed point, 16 integer bits and 16 fraction bits.
    typedef logic signed [FLOAT_W-1:0] p_float;

    typedef struct packed {
        p_float x;
        p_float y;
        p_float z;
    } p_float3;

    localparam int MULT_LAT = 3;
    localparam int ADD_LAT  = 2;
    localparam int PIPE_LAT = MULT_LAT + 2 * ADD_LAT;

    // Full-precision product, scaled back by the fraction width (floor).
    function automatic p_float fx_mul(input p_float a, input p_float b);
        return p_float'((64'(a) * 64'(b)) >>> FRAC_W);
    endfunction

    function automatic p_float fx_add(input p_float a, input p_float b);
        return a + b;
    endfunction

endpackage

`ifndef DP_ARITH_MACROS
`define DP_ARITH_MACROS

`define DP_MULT(name, a, b, y) \
    if (1) begin : name \
        p_float r_pipe [MULT_LAT]; \
        always_ff @(posedge clk) begin \
            r_pipe[0] <= fx_mul((a), (b)); \
            for (int k = 1; k < MULT_LAT; k++) r_pipe[k] <= r_pipe[k-1]; \
        end \
        assign y = r_pipe[MULT_LAT-1]; \
    end

`define DP_ADD(name, a, b, y) \
    if (1) begin : name \
        p_float r_pipe [ADD_LAT]; \
        always_ff @(posedge clk) begin \
            r_pipe[0] <= fx_add((a), (b)); \
            for (int k = 1; k < ADD_LAT; k++) r_pipe[k] <= r_pipe[k-1]; \
        end \
        assign y = r_pipe[ADD_LAT-1]; \
    end

`endif

// File: rtl/dot_result_fifo.sv
// First-word fall-through result buffer; head reads as zero while empty so no
// stale memory contents are ever visible on the outputs.
module dot_result_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_valid
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A pop frees the slot being written, so push-on-full is fine when popping.
    assign w_do_push = i_push && (!w_full || i_pop);
    assign w_do_pop  = i_pop && !w_empty;

    // NOTE: storage array has no reset; validity comes only from the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    assign o_valid = !w_empty;
    assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/dot_product_stage.sv
// Pipelined 3-component dot product with credit-based flow control into an
// output FIFO. Define DOT_PRODUCT_PERF_EN to add the stall_cycles counter.
module dot_product_stage
    import dot_product_stage_pkg::*;
#(
    parameter int TAG_W      = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  p_float3          in_a,
    input  p_float3          in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output p_float           out_dot,
    output logic [TAG_W-1:0] out_tag
`ifdef DOT_PRODUCT_PERF_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    localparam int CRED_W = $clog2(FIFO_DEPTH) + 1;
    localparam int RES_W  = TAG_W + FLOAT_W;

    generate
        if ((FIFO_DEPTH < PIPE_LAT) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of two and at least PIPE_LAT");
        end
    endgenerate

    logic              w_accept;
    logic              w_pop;
    logic              w_push;
    logic              w_fifo_valid;
    logic [RES_W-1:0]  w_head;
    logic [CRED_W-1:0] r_credits;

    p_float w_px;
    p_float w_py;
    p_float w_pz;
    p_float w_pz_dly;
    p_float w_sxy;
    p_float w_dot;

    logic [PIPE_LAT-1:0] r_vld_sr;
    logic [TAG_W-1:0]    r_tag_sr [PIPE_LAT];
    p_float              r_pz_dly [ADD_LAT];

    assign in_ready = (r_credits != '0);
    assign w_accept = in_valid && in_ready;
    assign w_pop    = w_fifo_valid && out_ready;

    // Free-running cores: data registers are never reset or stalled.
    `DP_MULT(mx, in_a.x, in_b.x, w_px)
    `DP_MULT(my, in_a.y, in_b.y, w_py)
    `DP_MULT(mz, in_a.z, in_b.z, w_pz)
    `DP_ADD(axy, w_px, w_py, w_sxy)
    `DP_ADD(asum, w_sxy, w_pz_dly, w_dot)

    always_ff @(posedge clk) begin
        r_pz_dly[0] <= w_pz;
        for (int k = 1; k < ADD_LAT; k++) r_pz_dly[k] <= r_pz_dly[k-1];
    end
    assign w_pz_dly = r_pz_dly[ADD_LAT-1];

    always_ff @(posedge clk) begin
        r_tag_sr[0] <= in_tag;
        for (int k = 1; k < PIPE_LAT; k++) r_tag_sr[k] <= r_tag_sr[k-1];
    end

    // Only the valid bits are reset, which is what discards in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_sr <= '0;
        end else begin
            r_vld_sr <= {r_vld_sr[PIPE_LAT-2:0], w_accept};
        end
    end

    assign w_push = r_vld_sr[PIPE_LAT-1];

    // NOTE: <= keeps each register sampling the pre-edge value of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits <= CRED_W'(FIFO_DEPTH);
        end else if (w_accept && !w_pop) begin
            r_credits <= r_credits - 1'b1;
        end else if (!w_accept && w_pop) begin
            r_credits <= r_credits + 1'b1;
        end
    end

    dot_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RES_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({r_tag_sr[PIPE_LAT-1], w_dot}),
        .i_pop   (out_ready),
        .o_rdata (w_head),
        .o_valid (w_fifo_valid)
    );

    assign out_valid          = w_fifo_valid;
    assign {out_tag, out_dot} = w_head;

`ifdef DOT_PRODUCT_PERF_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (in_valid && !in_ready && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_dot_product_stage.sv
// Randomized self-checking bench for dot_product_stage against an order-keeping
// reference queue of fixed-point dot products.
module tb_dot_product_stage;
    import dot_product_stage_pkg::*;

    localparam int TAG_W      = 8;
    localparam int FIFO_DEPTH = 16;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        p_float           dot;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    p_float3          in_a;
    p_float3          in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    p_float           out_dot;
    logic [TAG_W-1:0] out_tag;
`ifdef DOT_PRODUCT_PERF_EN
    logic [31:0]      stall_cycles;
`endif

    int   n_checks  = 0;
    int   n_errors  = 0;
    int   n_accepts = 0;
    int   n_pops    = 0;
    bit   saw_valid = 1'b0;
    res_t exp_q[$];
    res_t got_q[$];

    always #5 clk = ~clk;

    dot_product_stage #(
        .TAG_W      (TAG_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_dot      (out_dot),
        .out_tag      (out_tag)
`ifdef DOT_PRODUCT_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    // Each term is the exact product floored to 1/65536; the sum wraps at 32 bits.
    function automatic p_float ref_dot(input p_float3 a, input p_float3 b);
        longint acc;
        acc = ((longint'(a.x) * longint'(b.x)) >>> 16)
            + ((longint'(a.y) * longint'(b.y)) >>> 16)
            + ((longint'(a.z) * longint'(b.z)) >>> 16);
        return p_float'(acc[31:0]);
    endfunction

    function automatic p_float rand_val();
        return p_float'($urandom) >>> $urandom_range(0, 16);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back({in_tag, ref_dot(in_a, in_b)});
                n_accepts++;
            end
            if (out_valid && out_ready) begin
                got_q.push_back({out_tag, out_dot});
                n_pops++;
            end
            if (out_valid) saw_valid = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op();
        in_valid = 1'b1;
        in_a     = '{x: rand_val(), y: rand_val(), z: rand_val()};
        in_b     = '{x: rand_val(), y: rand_val(), z: rand_val()};
        in_tag   = TAG_W'($urandom);
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        exp_q.delete();
        got_q.delete();
        step();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid);
        end
        n_checks++;
        if (out_dot !== '0) begin
            n_errors++; $display("FAIL reset_out_dot: got %0h expected 0", out_dot);
        end
        n_checks++;
        if (out_tag !== '0) begin
            n_errors++; $display("FAIL reset_out_tag: got %0h expected 0", out_tag);
        end
    endtask

    task automatic test_single_op();
        bit early = 1'b0;
        out_ready = 1'b1;
        in_a      = '{x: 32'sh0001_0000, y: 32'sh0002_0000, z: 32'sh0003_0000};
        in_b      = '{x: 32'sh0004_0000, y: 32'sh0005_0000, z: 32'sh0006_0000};
        in_tag    = 8'h11;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        for (int cyc = 1; cyc <= PIPE_LAT; cyc++) begin
            if (out_valid) early = 1'b1;
            step();
        end
        n_checks++;
        if (early !== 1'b0) begin
            n_errors++; $display("FAIL single_latency_early: got out_valid before cycle %0d expected none", PIPE_LAT + 1);
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_errors++; $display("FAIL single_latency_valid: got %0b expected 1 at cycle %0d", out_valid, PIPE_LAT + 1);
        end
        n_checks++;
        if (out_dot !== 32'sh0020_0000) begin
            n_errors++; $display("FAIL single_dot: got %0h expected 00200000", out_dot);
        end
        n_checks++;
        if (out_tag !== 8'h11) begin
            n_errors++; $display("FAIL single_tag: got %0h expected 11", out_tag);
        end
        step();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_streaming();
        int drops  = 0;
        int budget = 200;
        out_ready = 1'b1;
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < 100; i++) begin
            drive_op();
            if (!in_ready) drops++;
            step();
        end
        in_valid = 1'b0;
        n_checks++;
        if (drops != 0) begin
            n_errors++; $display("FAIL stream_in_ready: got %0d low cycles expected 0", drops);
        end
        while (got_q.size() < 100 && budget > 0) begin
            step();
            budget--;
        end
        n_checks++;
        if (got_q.size() != 100) begin
            n_errors++; $display("FAIL stream_count: got %0d results expected 100", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_errors++; $display("FAIL stream_result[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_backpressure();
        int   acc0;
        res_t head;
        out_ready = 1'b0;
        exp_q.delete();
        got_q.delete();
        acc0 = n_accepts;
        repeat (FIFO_DEPTH + PIPE_LAT + 4) begin
            drive_op();
            step();
        end
        in_valid = 1'b0;
        n_checks++;
        if (n_accepts - acc0 != FIFO_DEPTH) begin
            n_errors++; $display("FAIL bp_accepts: got %0d expected %0d", n_accepts - acc0, FIFO_DEPTH);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++; $display("FAIL bp_in_ready: got %0b expected 0", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_errors++; $display("FAIL bp_out_valid: got %0b expected 1", out_valid);
        end
        head = {out_tag, out_dot};
        repeat (3) step();
        n_checks++;
        if ({out_tag, out_dot} !== head) begin
            n_errors++; $display("FAIL bp_hold: got %0h expected %0h", {out_tag, out_dot}, head);
        end
        n_checks++;
        if (exp_q.size() == 0 || head !== exp_q[0]) begin
            n_errors++; $display("FAIL bp_head: got %0h expected first accepted result", head);
        end
    endtask

    task automatic test_full_boundary();
        int acc0   = n_accepts;
        int pop0   = n_pops;
        int budget = 100;
        int total;
        drive_op();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (4) begin
            drive_op();
            step();
        end
        in_valid = 1'b0;
        n_checks++;
        if (n_accepts - acc0 != 1) begin
            n_errors++; $display("FAIL full_accepts: got %0d expected 1", n_accepts - acc0);
        end
        n_checks++;
        if (n_pops - pop0 != 1) begin
            n_errors++; $display("FAIL full_pops: got %0d expected 1", n_pops - pop0);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++; $display("FAIL full_credits: got in_ready %0b expected 0", in_ready);
        end
        total = FIFO_DEPTH + 1;
        out_ready = 1'b1;
        while (got_q.size() < total && budget > 0) begin
            step();
            budget--;
        end
        n_checks++;
        if (got_q.size() != total) begin
            n_errors++; $display("FAIL drain_count: got %0d results expected %0d", got_q.size(), total);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_errors++; $display("FAIL drain_result[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]);
            end
        end
        repeat (2 * PIPE_LAT) step();
        n_checks++;
        if (got_q.size() != total || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL drain_no_dup: got %0d results valid=%0b expected %0d valid=0", got_q.size(), out_valid, total);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL drain_credits: got in_ready %0b expected 1", in_ready);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        repeat (5) begin
            drive_op();
            step();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        exp_q.delete();
        got_q.delete();
        saw_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL midrst_in_ready: got %0b expected 1", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL midrst_out_valid: got %0b expected 0", out_valid);
        end
        repeat (3 * PIPE_LAT) step();
        n_checks++;
        if (saw_valid !== 1'b0 || got_q.size() != 0) begin
            n_errors++; $display("FAIL midrst_stale: got %0d stale results expected 0", got_q.size());
        end
    endtask

`ifdef DOT_PRODUCT_PERF_EN
    task automatic test_perf();
        apply_reset();
        repeat (FIFO_DEPTH + 10) begin
            drive_op();
            step();
        end
        in_valid = 1'b0;
        n_checks++;
        if (stall_cycles !== 32'd10) begin
            n_errors++; $display("FAIL perf_stall_cycles: got %0d expected 10", stall_cycles);
        end
        apply_reset();
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        test_reset();
        test_single_op();
        test_streaming();
        test_backpressure();
        test_full_boundary();
        test_reset_midstream();
`ifdef DOT_PRODUCT_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
